sfx_arbiter: RTL

- Shares the single square-wave sound pin between up to NUM_REQ game-event requesters, such as jump, hit, score and game-over.
- Each requester fires a one-cycle pulse. The block latches it as pending and grants the sound resource by fixed priority (index 0 highest). It then plays that effect's tone for a frame-counted duration and inserts a one-frame silent gap before the next effect.
- Sits between game logic and the audio output bit (uio_out[7]); frame timing comes from a one-cycle frame_tick derived from the VGA timing generator.

---
 rtl/sfx_pkg.sv | 57 +++++
 rtl/sfx_tone_gen.sv | 77 +++++++
 rtl/sfx_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sfx_pkg.sv
`default_nettype none
//--------------------------------------------------------------------------
// sfx_pkg: state encoding, per-effect tone tables and priority encoder.
// Rev 1.0 | optional: SFX_SWEEP_EN adds the per-frame sweep table
//--------------------------------------------------------------------------
package sfx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } sfx_state_t;

  localparam int SFX_NUM = 4;
  localparam int SFX_PERIOD [SFX_NUM] = '{12000, 20000, 8000, 30000};
  localparam int SFX_FRAMES [SFX_NUM] = '{4, 8, 2, 16};

  typedef struct packed {
    logic       valid;
    logic [7:0] idx;
  } prio_t;

  function automatic prio_t prio_encode(input logic [31:0] vec);
    prio_t r;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) begin
        r.valid = 1'b1;
        r.idx   = 8'(i);
      end
    end
    return r;
  endfunction

  // Table reads clamp degenerate entries so the tone counter always wraps.
  function automatic int sfx_period(input int idx);
    int p;
    p = (idx < SFX_NUM) ? SFX_PERIOD[idx] : 2;
    return (p < 2) ? 2 : p;
  endfunction

  function automatic int sfx_frames(input int idx);
    int f;
    f = (idx < SFX_NUM) ? SFX_FRAMES[idx] : 1;
    return (f < 1) ? 1 : f;
  endfunction

`ifdef SFX_SWEEP_EN
  localparam int SFX_SWEEP [SFX_NUM] = '{-200, 0, 500, 100};

  function automatic int sfx_sweep(input int idx);
    return (idx < SFX_NUM) ? SFX_SWEEP[idx] : 0;
  endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/sfx_tone_gen.sv
`default_nettype none
//--------------------------------------------------------------------------
// sfx_tone_gen: half-period counter, tone flop, mute gating, optional sweep.
// Rev 1.0 | optional: SFX_SWEEP_EN (frame_tick/sweep_in ports, sweep adder)
//--------------------------------------------------------------------------
module sfx_tone_gen #(
  parameter int PERIOD_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic                       run,
  input  logic                       mute,
  input  logic [PERIOD_W-1:0]        period_in,
`ifdef SFX_SWEEP_EN
  input  logic                       frame_tick,
  input  logic signed [PERIOD_W:0]   sweep_in,
`endif
  output logic                       sound
);

  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] half_cnt;
  logic                tone;
  logic                wrap;
  logic                tone_next;

  // ">=" lets a sweep that shrinks the period below half_cnt wrap at once.
  assign wrap      = (half_cnt >= (period - PERIOD_W'(1)));
  assign tone_next = tone ^ wrap;

`ifdef SFX_SWEEP_EN
  localparam logic signed [PERIOD_W+1:0] PERIOD_MIN = 2;
  localparam logic signed [PERIOD_W+1:0] PERIOD_MAX = {2'b00, {PERIOD_W{1'b1}}};

  logic signed [PERIOD_W+1:0] sweep_sum;
  logic [PERIOD_W-1:0]        period_swept;

  always_comb begin
    sweep_sum = $signed({2'b00, period}) + $signed({sweep_in[PERIOD_W], sweep_in});
    if (sweep_sum < PERIOD_MIN)
      period_swept = PERIOD_W'(2);
    else if (sweep_sum > PERIOD_MAX)
      period_swept = '1;
    else
      period_swept = sweep_sum[PERIOD_W-1:0];
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      period   <= '0;
      half_cnt <= '0;
      tone     <= 1'b0;
      sound    <= 1'b0;
    end else if (load) begin
      period   <= period_in;
      half_cnt <= '0;
      tone     <= 1'b0;
      sound    <= 1'b0;
    end else if (run) begin
      half_cnt <= wrap ? '0 : half_cnt + PERIOD_W'(1);
      tone     <= tone_next;
      sound    <= tone_next & ~mute;
`ifdef SFX_SWEEP_EN
      if (frame_tick)
        period <= period_swept;
`endif
    end else begin
      half_cnt <= '0;
      tone     <= 1'b0;
      sound    <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sfx_arbiter.sv
`default_nettype none
//--------------------------------------------------------------------------
// sfx_arbiter: fixed-priority sharing of the sound pin between effect requesters.
// Rev 1.0 | optional: SFX_SWEEP_EN (per-frame signed period sweep)
//--------------------------------------------------------------------------
module sfx_arbiter
  import sfx_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int PERIOD_W = 16,
  parameter int DUR_W    = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       frame_tick,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       mute,
  output logic                       sound,
  output logic                       busy,
  output logic                       grant,
  output logic [$clog2(NUM_REQ)-1:0] active_id
);

  localparam int ID_W = $clog2(NUM_REQ);

  sfx_state_t          state;
  sfx_state_t          state_next;
  logic [NUM_REQ-1:0]  pending;
  logic [NUM_REQ-1:0]  grant_onehot;
  logic [DUR_W-1:0]    dur;
  prio_t               prio;
  logic [ID_W-1:0]     win_id;
  logic                launch;
  logic                run;
  logic [PERIOD_W-1:0] period_load;
  logic [DUR_W-1:0]    frames_load;

  assign prio        = prio_encode(32'(pending));
  assign win_id      = ID_W'(prio.idx);
  assign period_load = PERIOD_W'(sfx_period(int'(win_id)));
  assign frames_load = DUR_W'(sfx_frames(int'(win_id)));

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (prio.valid) begin
          launch     = 1'b1;
          state_next = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // Preemption outranks the end-of-effect transition.
        if (prio.valid && (win_id < active_id))
          launch = 1'b1;
        else if (frame_tick && (dur == DUR_W'(1)))
          state_next = ST_GAP;
      end
      ST_GAP: begin
        if (frame_tick)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign grant_onehot = launch ? (NUM_REQ'(1) << win_id) : '0;
  assign run          = (state == ST_PLAY) && (state_next == ST_PLAY);
  assign busy         = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= '0;
      grant     <= 1'b0;
      active_id <= '0;
      dur       <= '0;
    end else begin
      // A request landing on its own grant edge survives, so the effect replays.
      pending <= (pending & ~grant_onehot) | req;
      grant   <= launch;
      if (launch) begin
        active_id <= win_id;
        dur       <= frames_load;
      end else if ((state == ST_PLAY) && frame_tick) begin
        dur <= dur - DUR_W'(1);
      end
    end
  end

`ifdef SFX_SWEEP_EN
  logic signed [PERIOD_W:0] sweep_val;
  assign sweep_val = (PERIOD_W+1)'(sfx_sweep(int'(active_id)));
`endif

  sfx_tone_gen #(
    .PERIOD_W (PERIOD_W)
  ) u_tone (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (launch),
    .run        (run),
    .mute       (mute),
    .period_in  (period_load),
`ifdef SFX_SWEEP_EN
    .frame_tick (frame_tick),
    .sweep_in   (sweep_val),
`endif
    .sound      (sound)
  );

endmodule
`default_nettype wire
